scene_load_ctrl: RTL and testbench
==================================

Name: scene_load_ctrl

Overview:
- Sequences scene uploads from the MCU over SPI into the ray-tracer's object register file, once per video frame.
- Sits between the 64-bit SPI word accumulator and the raytracing controller's object store.
- Requests data with recv_interrupt, validates a header word, and writes N object words.
- Commits the new scene with a single swap pulse, or aborts on protocol error or timeout.

Parameters:
MAX_OBJECTS, 16, maximum objects per scene; header count above this is a protocol error
ADDR_W, 4, object address width, $clog2(MAX_OBJECTS)
HDR_MAGIC, 8'hA5, required value of header bits [63:56]
TIMEOUT_CYCLES, 1000000, idle clk cycles allowed between words before abort (40 ms at 25 MHz)

Ports:
clk  in  1  system clock (CLK25MHZ domain)
rst_  in  1  synchronous, active-low reset
frame_start  in  1  one-cycle pulse at VGA vblank start
recv_dv  in  1  one-cycle strobe, recv_64bit valid
recv_64bit  in  64  accumulated SPI word
recv_interrupt  out  1  high while the transfer window is open (MCU data request)
obj_we  out  1  object register-file write strobe
obj_addr  out  ADDR_W  write address
obj_data  out  64  write data
obj_count  out  ADDR_W+1  object count of the last committed scene
scene_valid  out  1  sticky; at least one scene committed since reset
scene_swap  out  1  one-cycle commit pulse
err_proto  out  1  one-cycle pulse on protocol error
err_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- All outputs are registered.
- Reset (rst_=0 at posedge): state IDLE, all outputs 0, idx/count/timer 0. Reset during any state aborts with no swap and no error pulse.
- States: IDLE, HDR, LOAD, COMMIT. recv_interrupt = (state==HDR or state==LOAD).
- IDLE: frame_start -> HDR; the timer clears. recv_interrupt goes high the cycle after frame_start is sampled.
- HDR, on recv_dv:
  - bits[63:56]!=HDR_MAGIC or bits[7:0]>MAX_OBJECTS -> IDLE, err_proto pulse.
  - bits[7:0]==0 -> COMMIT with count=0.
  - Otherwise latch count=bits[7:0], idx=0 -> LOAD.
  - Bits [55:8] are ignored.
- LOAD, on recv_dv at edge t: during cycle t+1, obj_we=1, obj_addr=idx, obj_data=recv_64bit; idx increments. If idx==count-1 at edge t -> COMMIT.
- COMMIT (one cycle): next edge sets scene_swap=1 for one cycle, obj_count=count, scene_valid=1 -> IDLE. scene_swap is high the cycle after the final obj_we.
- obj_we, scene_swap, err_proto and err_timeout are single-cycle pulses. obj_addr and obj_data hold their last values when obj_we=0.
- Timer:
  - Counts in HDR and LOAD.
  - Clears on entry to HDR and on every recv_dv.
  - On reaching TIMEOUT_CYCLES-1 without recv_dv -> IDLE, err_timeout pulse. No swap, obj_count unchanged. Objects already written remain in the store, but the consumer must use only obj_count entries.
  - Simultaneous recv_dv and expiry: recv_dv wins; the word is processed and the timer clears.
- frame_start outside IDLE: ignored; it neither restarts nor aborts the transfer.
- recv_dv in IDLE or COMMIT: word discarded, err_proto pulse.
- Simultaneous frame_start and recv_dv in IDLE: the word is discarded with err_proto, and the state -> HDR.
- idx never exceeds count-1, so there is no address wrap. MAX_OBJECTS=16 with count=16 uses addresses 0..15.

Test Plan:
- Nominal: frame_start; header 64'hA500_0000_0000_0003; 3 words 0x11, 0x22, 0x33 -> obj_we at addr 0,1,2 with matching data; scene_swap one cycle after the last write; obj_count=3, scene_valid=1; recv_interrupt low after COMMIT.
- Empty scene: header count 0 -> no obj_we; scene_swap pulse; obj_count=0.
- Protocol errors (each case separately):
  - Header magic 8'h5A -> err_proto, IDLE.
  - Header count 17 -> err_proto, IDLE.
  - recv_dv while IDLE -> err_proto, no write.
  - In every case, obj_count keeps its previous value.
- Timeout (TIMEOUT_CYCLES=100): header count 4, 2 words, then silence -> err_timeout exactly 100 cycles after the last recv_dv; no swap; obj_count unchanged. Repeat with recv_dv on the expiry cycle -> no abort.
- frame_start pulsed mid-LOAD -> ignored; the load completes normally with a single swap.
- rst_=0 after 2 of 5 words -> all outputs 0 next cycle. A following frame_start and a full 5-object load commits obj_count=5.

Source files
------------

// File: rtl/scene_load_ctrl_if.sv
// scene_load_ctrl_if: SPI word input, object-store write port and scene status bundle
interface scene_load_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              frame_start;
  logic              recv_dv;
  logic [63:0]       recv_64bit;
  logic              recv_interrupt;
  logic              obj_we;
  logic [ADDR_W-1:0] obj_addr;
  logic [63:0]       obj_data;
  logic [ADDR_W:0]   obj_count;
  logic              scene_valid;
  logic              scene_swap;
  logic              err_proto;
  logic              err_timeout;
  modport master (
    output frame_start, recv_dv, recv_64bit,
    input  recv_interrupt, obj_we, obj_addr, obj_data, obj_count,
           scene_valid, scene_swap, err_proto, err_timeout
  );
  modport slave (
    input  frame_start, recv_dv, recv_64bit,
    output recv_interrupt, obj_we, obj_addr, obj_data, obj_count,
           scene_valid, scene_swap, err_proto, err_timeout
  );
endinterface

// File: rtl/scene_load_ctrl.sv
// scene_load_ctrl: per-frame scene upload sequencer from SPI words into the object store
module scene_load_ctrl #(
  parameter int          MAX_OBJECTS    = 16,
  parameter int          ADDR_W         = $clog2(MAX_OBJECTS),
  parameter logic [7:0]  HDR_MAGIC      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input logic            clk,
  input logic            rst_,
  scene_load_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, HDR, LOAD, COMMIT} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W:0]   count, count_n;
  logic [TW-1:0]     timer, timer_n;
  logic              we_n, swap_n, ep_n, et_n, valid_n;
  logic [ADDR_W-1:0] addr_n;
  logic [63:0]       data_n;
  logic [ADDR_W:0]   ocount_n;
  logic              hdr_bad, expired, last;
  assign hdr_bad = bus.recv_64bit[63:56] != HDR_MAGIC || bus.recv_64bit[7:0] > 8'(MAX_OBJECTS);
  assign expired = timer == TW'(TIMEOUT_CYCLES - 1);
  assign last    = (ADDR_W+1)'(idx) == count - (ADDR_W+1)'(1);
  // next-state and next-output decode; a word strobe always beats timer expiry
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    count_n  = count;
    timer_n  = timer + TW'(1);
    we_n     = 1'b0;
    swap_n   = 1'b0;
    ep_n     = 1'b0;
    et_n     = 1'b0;
    addr_n   = bus.obj_addr;
    data_n   = bus.obj_data;
    ocount_n = bus.obj_count;
    valid_n  = bus.scene_valid;
    case (state)
      IDLE: begin
        timer_n = '0;
        ep_n    = bus.recv_dv;
        state_n = bus.frame_start ? HDR : IDLE;
      end
      HDR: begin
        if (bus.recv_dv) begin
          timer_n = '0;
          if (hdr_bad) begin
            ep_n    = 1'b1;
            state_n = IDLE;
          end else begin
            count_n = bus.recv_64bit[ADDR_W:0];
            idx_n   = '0;
            state_n = bus.recv_64bit[7:0] == 8'd0 ? COMMIT : LOAD;
          end
        end else if (expired) begin
          et_n    = 1'b1;
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (bus.recv_dv) begin
          timer_n = '0;
          we_n    = 1'b1;
          addr_n  = idx;
          data_n  = bus.recv_64bit;
          idx_n   = idx + ADDR_W'(1);
          state_n = last ? COMMIT : LOAD;
        end else if (expired) begin
          et_n    = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        timer_n  = '0;
        ep_n     = bus.recv_dv;
        swap_n   = 1'b1;
        ocount_n = count;
        valid_n  = 1'b1;
        state_n  = IDLE;
      end
    endcase
  end
  // state, bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state              <= IDLE;
      idx                <= '0;
      count              <= '0;
      timer              <= '0;
      bus.recv_interrupt <= 1'b0;
      bus.obj_we         <= 1'b0;
      bus.obj_addr       <= '0;
      bus.obj_data       <= '0;
      bus.obj_count      <= '0;
      bus.scene_valid    <= 1'b0;
      bus.scene_swap     <= 1'b0;
      bus.err_proto      <= 1'b0;
      bus.err_timeout    <= 1'b0;
    end else begin
      state              <= state_n;
      idx                <= idx_n;
      count              <= count_n;
      timer              <= timer_n;
      bus.recv_interrupt <= state_n == HDR || state_n == LOAD;
      bus.obj_we         <= we_n;
      bus.obj_addr       <= addr_n;
      bus.obj_data       <= data_n;
      bus.obj_count      <= ocount_n;
      bus.scene_valid    <= valid_n;
      bus.scene_swap     <= swap_n;
      bus.err_proto      <= ep_n;
      bus.err_timeout    <= et_n;
    end
  end
endmodule

// File: tb/tb_scene_load_ctrl.sv
// tb_scene_load_ctrl: directed scene upload sequences with hand-computed expectations
module tb_scene_load_ctrl;
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  scene_load_ctrl_if #(.ADDR_W(4)) bus ();
  scene_load_ctrl #(.MAX_OBJECTS(16), .ADDR_W(4), .HDR_MAGIC(8'hA5), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk),
    .rst_(rst_),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic word(input logic [63:0] w);
    bus.recv_dv = 1'b1;
    bus.recv_64bit = w;
    tick();
    bus.recv_dv = 1'b0;
  endtask
  task automatic frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask
  initial begin
    bus.frame_start = 1'b0;
    bus.recv_dv = 1'b0;
    bus.recv_64bit = '0;
    ticks(2);
    chk("rst_ri", bus.recv_interrupt, 0);
    chk("rst_we", bus.obj_we, 0);
    chk("rst_cnt", bus.obj_count, 0);
    chk("rst_valid", bus.scene_valid, 0);
    rst_ = 1'b1;
    tick();
    // nominal 3-object scene
    frame();
    chk("nom_ri", bus.recv_interrupt, 1);
    word(64'hA500_0000_0000_0003);
    chk("nom_hdr_we", bus.obj_we, 0);
    word(64'h11);
    chk("nom_we0", bus.obj_we, 1);
    chk("nom_addr0", bus.obj_addr, 0);
    chk("nom_data0", bus.obj_data, 64'h11);
    word(64'h22);
    chk("nom_addr1", bus.obj_addr, 1);
    chk("nom_data1", bus.obj_data, 64'h22);
    word(64'h33);
    chk("nom_we2", bus.obj_we, 1);
    chk("nom_addr2", bus.obj_addr, 2);
    chk("nom_data2", bus.obj_data, 64'h33);
    chk("nom_ri_commit", bus.recv_interrupt, 0);
    chk("nom_swap_early", bus.scene_swap, 0);
    tick();
    chk("nom_swap", bus.scene_swap, 1);
    chk("nom_we_off", bus.obj_we, 0);
    chk("nom_cnt", bus.obj_count, 3);
    chk("nom_valid", bus.scene_valid, 1);
    chk("nom_hold_addr", bus.obj_addr, 2);
    tick();
    chk("nom_swap_pulse", bus.scene_swap, 0);
    // bad magic
    frame();
    word(64'h5A00_0000_0000_0003);
    chk("magic_ep", bus.err_proto, 1);
    chk("magic_ri", bus.recv_interrupt, 0);
    chk("magic_cnt", bus.obj_count, 3);
    tick();
    chk("magic_ep_pulse", bus.err_proto, 0);
    // header count 17
    frame();
    word(64'hA500_0000_0000_0011);
    chk("cnt17_ep", bus.err_proto, 1);
    chk("cnt17_ri", bus.recv_interrupt, 0);
    chk("cnt17_cnt", bus.obj_count, 3);
    tick();
    // word while idle
    word(64'h99);
    chk("idle_ep", bus.err_proto, 1);
    chk("idle_we", bus.obj_we, 0);
    chk("idle_cnt", bus.obj_count, 3);
    tick();
    // timeout after 2 of 4 words
    frame();
    word(64'hA500_0000_0000_0004);
    word(64'h1);
    word(64'h2);
    ticks(99);
    chk("to_early", bus.err_timeout, 0);
    chk("to_ri_open", bus.recv_interrupt, 1);
    tick();
    chk("to_et", bus.err_timeout, 1);
    chk("to_ri", bus.recv_interrupt, 0);
    chk("to_swap", bus.scene_swap, 0);
    chk("to_cnt", bus.obj_count, 3);
    tick();
    chk("to_et_pulse", bus.err_timeout, 0);
    chk("to_no_swap", bus.scene_swap, 0);
    // word lands on the expiry cycle
    frame();
    word(64'hA500_0000_0000_0002);
    word(64'hA);
    ticks(99);
    word(64'hB);
    chk("rescue_et", bus.err_timeout, 0);
    chk("rescue_we", bus.obj_we, 1);
    chk("rescue_addr", bus.obj_addr, 1);
    tick();
    chk("rescue_swap", bus.scene_swap, 1);
    chk("rescue_cnt", bus.obj_count, 2);
    tick();
    // frame_start mid-load is ignored
    frame();
    word(64'hA500_0000_0000_0003);
    word(64'h44);
    frame();
    chk("mid_ri", bus.recv_interrupt, 1);
    word(64'h55);
    chk("mid_addr1", bus.obj_addr, 1);
    word(64'h66);
    chk("mid_addr2", bus.obj_addr, 2);
    tick();
    chk("mid_swap", bus.scene_swap, 1);
    chk("mid_cnt", bus.obj_count, 3);
    tick();
    chk("mid_single_swap", bus.scene_swap, 0);
    tick();
    chk("mid_ri_closed", bus.recv_interrupt, 0);
    // empty scene
    frame();
    word(64'hA5FF_FFFF_FFFF_FF00);
    chk("empty_we", bus.obj_we, 0);
    tick();
    chk("empty_swap", bus.scene_swap, 1);
    chk("empty_cnt", bus.obj_count, 0);
    chk("empty_valid", bus.scene_valid, 1);
    tick();
    // reset mid-load, then a full 5-object scene
    frame();
    word(64'hA500_0000_0000_0005);
    word(64'h100);
    word(64'h101);
    rst_ = 1'b0;
    tick();
    chk("mrst_ri", bus.recv_interrupt, 0);
    chk("mrst_we", bus.obj_we, 0);
    chk("mrst_addr", bus.obj_addr, 0);
    chk("mrst_data", bus.obj_data, 0);
    chk("mrst_valid", bus.scene_valid, 0);
    chk("mrst_swap", bus.scene_swap, 0);
    chk("mrst_ep", bus.err_proto, 0);
    rst_ = 1'b1;
    tick();
    frame();
    word(64'hA500_0000_0000_0005);
    for (int i = 0; i < 5; i++) word(64'h200 + 64'(i));
    chk("five_addr4", bus.obj_addr, 4);
    chk("five_data4", bus.obj_data, 64'h204);
    tick();
    chk("five_swap", bus.scene_swap, 1);
    chk("five_cnt", bus.obj_count, 5);
    chk("five_valid", bus.scene_valid, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
